if_stage_pipe: RTL

- Parametrised, clocked instruction-fetch stage for the MIPS-16b pipeline.
- Owns the program counter register and the PC incrementer, and drives the instruction-memory address.
- Registers the fetched instruction, PC and PC+INC into an IF/ID pipeline register.
- Supports stall, flush, branch/jump redirect, and a saturating fetch counter for performance monitoring.

---
 rtl/mips16_pkg.sv | 19 +
 rtl/if_stage_pipe_pc_incr.sv | 13 +
 rtl/if_stage_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mips16_pkg.sv
// Shared defaults and types for the MIPS-16b fetch pipeline.
package mips16_pkg;

    localparam int          DEF_AW         = 32;
    localparam int          DEF_IW         = 32;
    localparam int          DEF_CNT_W      = 16;
    localparam int          DEF_ALIGN_BITS = 2;
    localparam logic [31:0] DEF_INC_VAL    = 32'd4;
    localparam logic [31:0] DEF_RESET_PC   = 32'd0;
    localparam logic [31:0] DEF_NOP_INSTR  = 32'd0;

    // What the PC register does this cycle.
    typedef enum logic [1:0] {
        FA_ADVANCE  = 2'd0,
        FA_HOLD     = 2'd1,
        FA_REDIRECT = 2'd2
    } fetch_act_e;

endpackage

// File: rtl/if_stage_pipe_pc_incr.sv
// Constant-increment PC adder; carry-out is exposed but wrap-around is the intended behaviour.
module pc_incr #(
    parameter int             AW      = 32,
    parameter logic [AW-1:0]  INC_VAL = AW'(4)
) (
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] pc_next,
    output logic          cout
);

    assign {cout, pc_next} = {1'b0, pc} + {1'b0, INC_VAL};

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, fetch counter, misalignment flag.
module if_stage_pipe
    import mips16_pkg::*;
#(
    parameter int            AW         = DEF_AW,
    parameter int            IW         = DEF_IW,
    parameter logic [AW-1:0] INC_VAL    = AW'(DEF_INC_VAL),
    parameter logic [AW-1:0] RESET_PC   = AW'(DEF_RESET_PC),
    parameter logic [IW-1:0] NOP_INSTR  = IW'(DEF_NOP_INSTR),
    parameter int            CNT_W      = DEF_CNT_W,
    parameter int            ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [AW-1:0]    redirect_pc,
    output logic [AW-1:0]    imem_addr,
    input  logic [IW-1:0]    imem_rdata,
    output logic [IW-1:0]    if_id_instr,
    output logic [AW-1:0]    if_id_pc,
    output logic [AW-1:0]    if_id_pc_inc,
    output logic             if_id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [AW-1:0]    ALIGN_MASK = AW'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [AW-1:0]    pc_q, pc_d, pc_next;
    logic             pc_cout_unused;
    logic [IW-1:0]    instr_q, instr_d;
    logic [AW-1:0]    ifpc_q, ifpc_d;
    logic [AW-1:0]    ifpc_inc_q, ifpc_inc_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fetch_act_e       act;

    pc_incr #(
        .AW      (AW),
        .INC_VAL (INC_VAL)
    ) u_pc_incr (
        .pc      (pc_q),
        .pc_next (pc_next),
        .cout    (pc_cout_unused)
    );

    always_comb begin
        act = FA_ADVANCE;
        if (redirect_valid) begin
            act = FA_REDIRECT;
        end else if (stall) begin
            act = FA_HOLD;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        ifpc_d     = ifpc_q;
        ifpc_inc_d = ifpc_inc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (act)
            FA_REDIRECT: begin
                pc_d  = redirect_pc & ~ALIGN_MASK;
                err_d = err_q | (|(redirect_pc & ALIGN_MASK));
            end
            FA_ADVANCE:  pc_d = pc_next;
            default:     pc_d = pc_q;
        endcase

        // A redirect squashes the in-flight fetch exactly like a flush does.
        if (act == FA_REDIRECT || flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (act == FA_ADVANCE) begin
            instr_d    = imem_rdata;
            ifpc_d     = pc_q;
            ifpc_inc_d = pc_next;
            valid_d    = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            ifpc_q     <= '0;
            ifpc_inc_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            ifpc_q     <= ifpc_d;
            ifpc_inc_q <= ifpc_inc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc     = ifpc_q;
    assign if_id_pc_inc = ifpc_inc_q;
    assign if_id_valid  = valid_q;
    assign misalign_err = err_q;
    assign fetch_count  = cnt_q;

endmodule
